// File: rtl/hba_gpio_debounce.sv
// Per-pin synchronizer plus STABLE/COUNTING debounce filter with optional edge pulses.
// Define GPIO_DEBOUNCE_EDGE_EN to build the pin_rise/pin_fall pulse logic; otherwise both are tied to 0.
module hba_gpio_debounce #(
  parameter int unsigned NUM_PINS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                hba_clk,
  input  logic                hba_reset_n,
  input  logic                debounce_en,
  input  logic [NUM_PINS-1:0] pin_raw,
  output logic [NUM_PINS-1:0] pin_clean,
  output logic [NUM_PINS-1:0] pin_rise,
  output logic [NUM_PINS-1:0] pin_fall,
  output logic                pin_busy
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [NUM_PINS-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0]  sync;
  state_e               state_q [NUM_PINS];
  state_e               state_d [NUM_PINS];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PINS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_PINS];
  logic [NUM_PINS-1:0]  load;
  logic [NUM_PINS-1:0]  clean_q, clean_d;
  logic                 busy_q, busy_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int unsigned i = 0; i < NUM_PINS; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      clean_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      sync_q[0] <= pin_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int unsigned i = 0; i < NUM_PINS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      clean_q <= clean_d;
      busy_q  <= busy_d;
    end
  end

  // Bypass forces every pin STABLE and lets the clean level track sync directly.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      load[i]    = 1'b0;
      if (!debounce_en) begin
        state_d[i] = ST_STABLE;
        cnt_d[i]   = '0;
        load[i]    = 1'b1;
      end else begin
        unique case (state_q[i])
          ST_STABLE: begin
            if (sync[i] != clean_q[i]) begin
              state_d[i] = ST_COUNTING;
              cnt_d[i]   = CNT_ONE;
            end else begin
              cnt_d[i] = '0;
            end
          end
          ST_COUNTING: begin
            if (sync[i] == clean_q[i]) begin
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
              load[i]    = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    clean_d = clean_q;
    busy_d  = 1'b0;
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      if (load[i]) clean_d[i] = sync[i];
      if (state_d[i] == ST_COUNTING) busy_d = 1'b1;
    end
  end

  assign pin_clean = clean_q;
  assign pin_busy  = busy_q;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic [NUM_PINS-1:0] rise_q, fall_q;

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= clean_d & ~clean_q;
      fall_q <= ~clean_d & clean_q;
    end
  end

  assign pin_rise = rise_q;
  assign pin_fall = fall_q;
`else
  assign pin_rise = '0;
  assign pin_fall = '0;
`endif

endmodule
